// File: rtl/locker_pkg.sv
// Shared types and width helpers for the parametrised digital locker.
package locker_pkg;

    typedef enum logic [2:0] {
        StEntry,
        StCompare,
        StUnlocked,
        StProgram,
        StLockout
    } state_t;

    // Bits needed to hold 0..max_val, never less than one.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        if (max_val < 1) begin
            return 1;
        end
        return $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/locker_lockout_timer.sv
// Loadable down-counter; stops at zero and flags expiry while it holds one.
module locker_lockout_timer #(
    parameter int unsigned TW = 10
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          load,
    input  logic [TW-1:0] val,
    output logic          expire
);

    logic [TW-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = val;
        end else if (count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expire = (count_q == TW'(1));

endmodule

// File: rtl/param_digital_locker.sv
// Digit-entry code lock with attempt limit, timed lockout, relock and code reprogramming.
module param_digital_locker
    import locker_pkg::*;
#(
    parameter int unsigned DIGIT_W        = 4,
    parameter int unsigned CODE_LEN       = 4,
    parameter int unsigned MAX_ATTEMPTS   = 3,
    parameter int unsigned LOCKOUT_CYCLES = 1000,
    parameter logic [DIGIT_W*CODE_LEN-1:0] DEFAULT_CODE = 16'h4321,
    localparam int unsigned AW = $clog2(MAX_ATTEMPTS + 1),
    localparam int unsigned IW = $clog2(CODE_LEN + 1)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               digit_valid,
    input  logic [DIGIT_W-1:0] digit_in,
    input  logic               clear,
    input  logic               relock,
    input  logic               prog_en,
    output logic               unlocked,
    output logic               locked,
    output logic               prog_mode,
    output logic               bad_attempt,
    output logic [AW-1:0]      attempts_left,
    output logic [IW-1:0]      digit_count
);

    localparam int unsigned CW = DIGIT_W * CODE_LEN;
    localparam int unsigned TW = cnt_width(LOCKOUT_CYCLES);
    localparam logic [IW-1:0] LastIdx = IW'(CODE_LEN - 1);
    localparam logic [AW-1:0] MaxAtt  = AW'(MAX_ATTEMPTS);
    localparam logic [TW-1:0] LockVal = TW'(LOCKOUT_CYCLES);

    state_t         state_q, state_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic [CW-1:0]  entry_q, entry_d;
    logic [CW-1:0]  shadow_q, shadow_d;
    logic [CW-1:0]  code_q, code_d;
    logic [AW-1:0]  att_q, att_d;
    logic           bad_d;
    logic           timer_load;
    logic           timer_expire;

    logic           unlocked_q, locked_q, prog_q, bad_q;
    logic [IW-1:0]  count_q;

    locker_lockout_timer #(
        .TW(TW)
    ) u_timer (
        .clk    (clk),
        .reset_n(reset_n),
        .load   (timer_load),
        .val    (LockVal),
        .expire (timer_expire)
    );

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        entry_d    = entry_q;
        shadow_d   = shadow_q;
        code_d     = code_q;
        att_d      = att_q;
        bad_d      = 1'b0;
        timer_load = 1'b0;

        unique case (state_q)
            StEntry: begin
                if (clear) begin
                    idx_d = '0;
                end else if (digit_valid) begin
                    entry_d[idx_q*DIGIT_W +: DIGIT_W] = digit_in;
                    if (idx_q == LastIdx) begin
                        idx_d   = '0;
                        state_d = StCompare;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            StCompare: begin
                if (entry_q == code_q) begin
                    state_d = StUnlocked;
                    att_d   = MaxAtt;
                end else begin
                    bad_d = 1'b1;
                    if (att_q <= AW'(1)) begin
                        att_d   = '0;
                        state_d = StLockout;
                        // A zero duration leaves the timer idle, so lockout never expires.
                        timer_load = (LOCKOUT_CYCLES != 0);
                    end else begin
                        att_d   = att_q - 1'b1;
                        state_d = StEntry;
                    end
                end
            end
            StUnlocked: begin
                if (relock) begin
                    state_d = StEntry;
                end else if (prog_en) begin
                    idx_d   = '0;
                    state_d = StProgram;
                end
            end
            StProgram: begin
                if (clear) begin
                    idx_d   = '0;
                    state_d = StUnlocked;
                end else if (digit_valid) begin
                    shadow_d[idx_q*DIGIT_W +: DIGIT_W] = digit_in;
                    if (idx_q == LastIdx) begin
                        code_d  = shadow_d;
                        idx_d   = '0;
                        state_d = StUnlocked;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            StLockout: begin
                if (timer_expire) begin
                    att_d   = MaxAtt;
                    state_d = StEntry;
                end
            end
            default: begin
                state_d = StEntry;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= StEntry;
            idx_q      <= '0;
            entry_q    <= '0;
            shadow_q   <= '0;
            code_q     <= DEFAULT_CODE;
            att_q      <= MaxAtt;
            unlocked_q <= 1'b0;
            locked_q   <= 1'b0;
            prog_q     <= 1'b0;
            bad_q      <= 1'b0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            entry_q    <= entry_d;
            shadow_q   <= shadow_d;
            code_q     <= code_d;
            att_q      <= att_d;
            // Status flags follow the next state so they line up with state_q.
            unlocked_q <= (state_d == StUnlocked) || (state_d == StProgram);
            locked_q   <= (state_d == StLockout);
            prog_q     <= (state_d == StProgram);
            bad_q      <= bad_d;
            count_q    <= ((state_d == StEntry) || (state_d == StProgram)) ? idx_d : '0;
        end
    end

    assign unlocked      = unlocked_q;
    assign locked        = locked_q;
    assign prog_mode     = prog_q;
    assign bad_attempt   = bad_q;
    assign attempts_left = att_q;
    assign digit_count   = count_q;

endmodule

// File: tb/tb_param_digital_locker.sv
// Vector-table bench for param_digital_locker with a scoreboard of expected output bundles.
module tb_param_digital_locker;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       digit_valid = 1'b0;
    logic [3:0] digit_in = '0;
    logic       clear = 1'b0;
    logic       relock = 1'b0;
    logic       prog_en = 1'b0;
    logic       unlocked, locked, prog_mode, bad_attempt;
    logic [1:0] attempts_left;
    logic [2:0] digit_count;

    int n_checks = 0;
    int n_fail   = 0;

    // Expected bundle: {unlocked, locked, prog_mode, bad_attempt, attempts_left, digit_count}
    typedef struct {
        logic       rst_n;
        logic       dv;
        logic [3:0] d;
        logic       clr;
        logic       rl;
        logic       pe;
        logic [8:0] exp_out;
    } vec_t;

    typedef struct {
        int         step;
        logic [8:0] val;
    } sb_t;

    vec_t vecs[$];
    sb_t  sb[$];
    int   step_no = 0;

    param_digital_locker #(
        .LOCKOUT_CYCLES(8)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .digit_valid  (digit_valid),
        .digit_in     (digit_in),
        .clear        (clear),
        .relock       (relock),
        .prog_en      (prog_en),
        .unlocked     (unlocked),
        .locked       (locked),
        .prog_mode    (prog_mode),
        .bad_attempt  (bad_attempt),
        .attempts_left(attempts_left),
        .digit_count  (digit_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic add(input logic rst_n, input logic dv, input logic [3:0] d, input logic clr,
                       input logic rl, input logic pe, input logic unl, input logic lck,
                       input logic pm, input logic bad, input logic [1:0] att,
                       input logic [2:0] cnt);
        vec_t v;
        v.rst_n   = rst_n;
        v.dv      = dv;
        v.d       = d;
        v.clr     = clr;
        v.rl      = rl;
        v.pe      = pe;
        v.exp_out = {unl, lck, pm, bad, att, cnt};
        vecs.push_back(v);
    endtask

    task automatic idle(input logic unl, input logic lck, input logic pm, input logic bad,
                        input logic [1:0] att, input logic [2:0] cnt);
        add(1, 0, 0, 0, 0, 0, unl, lck, pm, bad, att, cnt);
    endtask

    // Four digits in ENTRY; the last one moves to COMPARE.
    task automatic ent4(input logic [3:0] d0, input logic [3:0] d1, input logic [3:0] d2,
                        input logic [3:0] d3, input logic [1:0] att);
        add(1, 1, d0, 0, 0, 0, 0, 0, 0, 0, att, 1);
        add(1, 1, d1, 0, 0, 0, 0, 0, 0, 0, att, 2);
        add(1, 1, d2, 0, 0, 0, 0, 0, 0, 0, att, 3);
        add(1, 1, d3, 0, 0, 0, 0, 0, 0, 0, att, 0);
    endtask

    // Four digits in PROGRAM; the last one commits and returns to UNLOCKED.
    task automatic prg4(input logic [3:0] d0, input logic [3:0] d1, input logic [3:0] d2,
                        input logic [3:0] d3, input logic [1:0] att);
        add(1, 1, d0, 0, 0, 0, 1, 0, 1, 0, att, 1);
        add(1, 1, d1, 0, 0, 0, 1, 0, 1, 0, att, 2);
        add(1, 1, d2, 0, 0, 0, 1, 0, 1, 0, att, 3);
        add(1, 1, d3, 0, 0, 0, 1, 0, 0, 0, att, 0);
    endtask

    task automatic run_table();
        sb_t e;
        for (int i = 0; i < vecs.size(); i++) begin
            reset_n     = vecs[i].rst_n;
            digit_valid = vecs[i].dv;
            digit_in    = vecs[i].d;
            clear       = vecs[i].clr;
            relock      = vecs[i].rl;
            prog_en     = vecs[i].pe;
            sb.push_back('{step: step_no, val: vecs[i].exp_out});
            step_no++;
            @(posedge clk);
            #1;
            e = sb.pop_front();
            check($sformatf("step %0d outputs", e.step),
                  32'({unlocked, locked, prog_mode, bad_attempt, attempts_left, digit_count}),
                  32'(e.val));
        end
        reset_n = 1'b1; digit_valid = 1'b0; clear = 1'b0; relock = 1'b0; prog_en = 1'b0;
        vecs.delete();
    endtask

    initial begin
        int  n;
        logic hold_ok;

        // Reset, correct code, then three wrong codes into lockout.
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0);
        ent4(1, 2, 3, 4, 3);
        idle(1, 0, 0, 0, 3, 0);
        add(1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 3, 0);
        ent4(1, 2, 3, 5, 3);
        add(1, 1, 7, 0, 0, 0, 0, 0, 0, 1, 2, 0);   // digit during COMPARE is dropped
        idle(0, 0, 0, 0, 2, 0);
        ent4(1, 2, 3, 5, 2);
        idle(0, 0, 0, 1, 1, 0);
        ent4(1, 2, 3, 5, 1);
        idle(0, 1, 0, 1, 0, 0);
        run_table();

        // Lockout must last exactly 8 cycles while ignoring digits.
        n = 0;
        hold_ok = 1'b1;
        for (int c = 0; c < 20; c++) begin
            digit_valid = 1'b1;
            digit_in    = 4'd4;
            @(posedge clk);
            #1;
            n++;
            if (!locked) break;
            if (attempts_left != 2'd0 || digit_count != 3'd0) hold_ok = 1'b0;
        end
        digit_valid = 1'b0;
        check("lockout length in cycles", n + 0, 8);
        check("lockout holds attempts/count at 0", 32'(hold_ok), 1);
        check("attempts after lockout", 32'(attempts_left), 3);
        check("digit_count after lockout", 32'(digit_count), 0);

        // Clear mid-entry, clear winning over a digit, then unlock.
        add(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 3, 1);
        add(1, 1, 2, 0, 0, 0, 0, 0, 0, 0, 3, 2);
        add(1, 1, 7, 1, 0, 0, 0, 0, 0, 0, 3, 0);
        ent4(1, 2, 3, 4, 3);
        idle(1, 0, 0, 0, 3, 0);
        // Reprogram to 9,9,0,1 and verify old code fails, new code works.
        add(1, 0, 0, 0, 0, 1, 1, 0, 1, 0, 3, 0);
        prg4(9, 9, 0, 1, 3);
        add(1, 1, 5, 0, 0, 0, 1, 0, 0, 0, 3, 0);   // digits ignored while unlocked
        add(1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 3, 0);
        ent4(1, 2, 3, 4, 3);
        idle(0, 0, 0, 1, 2, 0);
        ent4(9, 9, 0, 1, 2);
        idle(1, 0, 0, 0, 3, 0);
        // Aborted programming keeps the code; relock beats prog_en.
        add(1, 0, 0, 0, 0, 1, 1, 0, 1, 0, 3, 0);
        add(1, 1, 7, 0, 0, 0, 1, 0, 1, 0, 3, 1);
        add(1, 1, 7, 0, 0, 0, 1, 0, 1, 0, 3, 2);
        add(1, 0, 0, 0, 1, 0, 1, 0, 1, 0, 3, 2);   // relock ignored in PROGRAM
        add(1, 0, 0, 1, 0, 0, 1, 0, 0, 0, 3, 0);
        add(1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 3, 0);
        ent4(9, 9, 0, 1, 3);
        idle(1, 0, 0, 0, 3, 0);
        // Reset during PROGRAM restores the default code.
        add(1, 0, 0, 0, 0, 1, 1, 0, 1, 0, 3, 0);
        add(1, 1, 9, 0, 0, 0, 1, 0, 1, 0, 3, 1);
        add(0, 1, 9, 0, 0, 0, 0, 0, 0, 0, 3, 0);
        ent4(1, 2, 3, 4, 3);
        idle(1, 0, 0, 0, 3, 0);
        add(1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 3, 0);
        // Reset during LOCKOUT.
        ent4(5, 5, 5, 5, 3);
        idle(0, 0, 0, 1, 2, 0);
        ent4(5, 5, 5, 5, 2);
        idle(0, 0, 0, 1, 1, 0);
        ent4(5, 5, 5, 5, 1);
        idle(0, 1, 0, 1, 0, 0);
        idle(0, 1, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0);
        idle(0, 0, 0, 0, 3, 0);
        idle(0, 0, 0, 0, 3, 0);
        ent4(1, 2, 3, 4, 3);
        idle(1, 0, 0, 0, 3, 0);
        run_table();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
